// File: rtl/serial_pad_out.sv
// Serial pad output engine: shifts NUM_PADS button words to a console over latch/clock/data, (S)NES or 3DO framing.
// Optional stall watchdog enabled by defining SERIAL_PAD_OUT_WATCHDOG_EN.
module serial_pad_out #(
  parameter int NUM_PADS    = 2,
  parameter int PAD_BITS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_CYCLES  = 65535
) (
  input  logic                         system_clock,
  input  logic                         system_reset_n,
  input  logic                         mode,
  input  logic [NUM_PADS*PAD_BITS-1:0] pad_state,
  input  logic                         pad_valid,
  input  logic                         con_latch,
  input  logic                         con_clk,
  output logic                         con_data,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int TOTAL = NUM_PADS * PAD_BITS;
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FILL} state_t;

  // Index 0 is the first synchroniser flop, SYNC_STAGES-1 the last, SYNC_STAGES the history flop.
  logic [SYNC_STAGES:0] lat_sync_q, clk_sync_q;
  logic                 lat_rise, lat_fall, clk_rise, clk_fall, clk_act;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [TOTAL-1:0]     shift_q, stage_q, shift_d;
  logic                 mode_q, busy_q, frame_done_q;
`ifdef SERIAL_PAD_OUT_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0]        wdt_q;
`endif

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      lat_sync_q <= '0;
      clk_sync_q <= '0;
    end else begin
      lat_sync_q <= {lat_sync_q[SYNC_STAGES-1:0], con_latch};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-1:0], con_clk};
    end
  end

  assign lat_rise = lat_sync_q[SYNC_STAGES-1] & ~lat_sync_q[SYNC_STAGES];
  assign lat_fall = ~lat_sync_q[SYNC_STAGES-1] & lat_sync_q[SYNC_STAGES];
  assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES];
  assign clk_fall = ~clk_sync_q[SYNC_STAGES-1] & clk_sync_q[SYNC_STAGES];
  // Any latch edge in the same cycle swallows the clock edge.
  assign clk_act  = (mode_q ? clk_fall : clk_rise) & ~lat_rise & ~lat_fall;
  assign shift_d  = {shift_q[TOTAL-2:0], 1'b1};

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '1;
      stage_q      <= '1;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIAL_PAD_OUT_WATCHDOG_EN
      wdt_q        <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (pad_valid) stage_q <= pad_state;

      if (lat_rise) begin
        if (state_q == IDLE) mode_q <= mode;
        state_q <= LOAD;
        cnt_q   <= '0;
        shift_q <= stage_q;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          LOAD: begin
            shift_q <= stage_q;
            cnt_q   <= '0;
            if (lat_fall) state_q <= SHIFT;
          end
          SHIFT: begin
            if (clk_act) begin
              if (cnt_q == LAST) begin
                // Fill value marks end of chain: 1 for (S)NES, 0 for 3DO.
                shift_q      <= {TOTAL{~mode_q}};
                frame_done_q <= 1'b1;
                state_q      <= FILL;
              end else begin
                shift_q <= shift_d;
                cnt_q   <= cnt_q + 1'b1;
              end
            end
          end
          FILL: ;
          default: state_q <= IDLE;
        endcase
      end

`ifdef SERIAL_PAD_OUT_WATCHDOG_EN
      if (lat_rise | lat_fall | clk_rise | clk_fall) begin
        wdt_q <= '0;
      end else if (state_q == LOAD || state_q == SHIFT) begin
        if (wdt_q == WW'(WDT_CYCLES - 1)) begin
          state_q <= IDLE;
          shift_q <= '1;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          wdt_q   <= '0;
        end else begin
          wdt_q <= wdt_q + 1'b1;
        end
      end else begin
        wdt_q <= '0;
      end
`endif
    end
  end

  assign con_data   = shift_q[TOTAL-1];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
